// File: rtl/ifu_fetch_ctrl_if.sv
// Fetch controller bus bundle: I-cache request/response and instruction-queue head.
// master = fetch controller, slave = cache/dispatch side.
interface ifu_fetch_ctrl_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_valid;
  logic [31:0] ic_inst;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic        iq_pred_taken;
  logic [31:0] iq_pred_pc;
  logic        iq_ready;

  modport master (
    output ic_req, ic_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_pc,
    input  ic_valid, ic_inst, iq_ready
  );

  modport slave (
    input  ic_req, ic_addr, iq_valid, iq_inst, iq_pc, iq_pred_taken, iq_pred_pc,
    output ic_valid, ic_inst, iq_ready
  );
endinterface

// File: rtl/ifu_fetch_ctrl.sv
// IFU fetch controller: one outstanding I-cache request, static predecode
// (JAL taken, backward branches taken) and an in-order instruction queue.
module ifu_fetch_ctrl #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rdy,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  ifu_fetch_ctrl_if.master      bus
);

  localparam int unsigned PW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW + 1)'(IQ_DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [PW:0]   count_q, count_d, count_after;

  logic [31:0] inst_q  [IQ_DEPTH];
  logic [31:0] pc_q    [IQ_DEPTH];
  logic        taken_q [IQ_DEPTH];
  logic [31:0] pred_q  [IQ_DEPTH];

  logic        push, pop;
  logic        pred_taken;
  logic [31:0] pred_pc, imm_b, imm_j;

  // Predecode of the returned word, relative to the address it was fetched from
  assign imm_b = {{20{bus.ic_inst[31]}}, bus.ic_inst[7], bus.ic_inst[30:25],
                  bus.ic_inst[11:8], 1'b0};
  assign imm_j = {{12{bus.ic_inst[31]}}, bus.ic_inst[19:12], bus.ic_inst[20],
                  bus.ic_inst[30:21], 1'b0};

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = req_addr_q + 32'd4;
    case (bus.ic_inst[6:0])
      7'b1101111: begin
        pred_taken = 1'b1;
        pred_pc    = req_addr_q + imm_j;
      end
      7'b1100011: begin
        pred_taken = imm_b[31];
        if (imm_b[31]) pred_pc = req_addr_q + imm_b;
      end
      default: ;
    endcase
  end

  assign pop         = (count_q != '0) && bus.iq_ready;
  assign count_after = count_q + (PW + 1)'(1) - (PW + 1)'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_addr_d = req_addr_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    push       = 1'b0;
    if (rdy) begin
      if (flush) begin
        count_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        fetch_pc_d = flush_pc;
        // An issued request is never aborted; its response must still be absorbed
        if (state_q == WAIT) state_d = bus.ic_valid ? IDLE : DROP;
      end else begin
        case (state_q)
          IDLE: begin
            if (count_q < DEPTH_C) begin
              req_addr_d = fetch_pc_q;
              state_d    = WAIT;
            end
          end
          WAIT: begin
            if (bus.ic_valid) begin
              push       = 1'b1;
              fetch_pc_d = pred_pc;
              if (count_after < DEPTH_C) req_addr_d = pred_pc;
              else                       state_d    = IDLE;
            end
          end
          DROP: begin
            if (bus.ic_valid) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
        count_d = count_q + (PW + 1)'(push) - (PW + 1)'(pop);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= RESET_PC;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      for (int i = 0; i < IQ_DEPTH; i++) begin
        inst_q[i]  <= '0;
        pc_q[i]    <= '0;
        taken_q[i] <= 1'b0;
        pred_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_addr_q <= req_addr_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      if (push) begin
        inst_q[tail_q]  <= bus.ic_inst;
        pc_q[tail_q]    <= req_addr_q;
        taken_q[tail_q] <= pred_taken;
        pred_q[tail_q]  <= pred_pc;
      end
    end
  end

  assign bus.ic_req        = (state_q == WAIT) || (state_q == DROP);
  assign bus.ic_addr       = req_addr_q;
  assign bus.iq_valid      = (count_q != '0);
  assign bus.iq_inst       = inst_q[head_q];
  assign bus.iq_pc         = pc_q[head_q];
  assign bus.iq_pred_taken = taken_q[head_q];
  assign bus.iq_pred_pc    = pred_q[head_q];

endmodule
